// File: rtl/seven_segment_mux.sv
// seven_segment_mux: time-multiplexed 8-digit hex seven-segment driver with frame-latched inputs
module seven_segment_mux #(
  parameter int CLK_FREQUENCY          = 100_000_000,
  parameter int MIN_SEGMENT_DISPLAY_US = 10_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] display_val,
  input  logic [7:0]  dp,
  input  logic        blank,
  output logic [6:0]  segments,
  output logic        dp_out,
  output logic [7:0]  an_out,
  output logic        frame_done
);
  localparam int DIGIT_CLOCKS = CLK_FREQUENCY / 1_000_000 * MIN_SEGMENT_DISPLAY_US;
  localparam int TW = DIGIT_CLOCKS < 2 ? 1 : $clog2(DIGIT_CLOCKS);
  localparam logic [16*7-1:0] SEG = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  if (DIGIT_CLOCKS < 2) begin : g_bad_timing
    $fatal(1, "seven_segment_mux: DIGIT_CLOCKS must be at least 2");
  end

  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    digit_q, digit_d;
  logic          loaded_q;
  logic          wrap_q, wrap_d;
  logic [31:0]   val_q;
  logic [7:0]    dp_q;
  logic          blank_q;
  logic          last, reload;
  logic [3:0]    nib;
  logic [6:0]    seg_d;
  logic [7:0]    an_d;
  logic          dp_d;

  // Sequencing and output decode from the current digit and frame snapshot
  always_comb begin
    last    = loaded_q && timer_q == TW'(DIGIT_CLOCKS - 1);
    timer_d = (!loaded_q || last) ? '0 : timer_q + 1'b1;
    digit_d = last ? digit_q + 3'd1 : digit_q;
    wrap_d  = last && digit_q == 3'd7;
    reload  = !loaded_q || wrap_d;
    nib     = val_q[{digit_q, 2'b00} +: 4];
    an_d    = blank_q ? 8'hFF : ~(8'b1 << digit_q);
    seg_d   = blank_q ? 7'h7F : SEG[nib*7 +: 7];
    dp_d    = blank_q | ~dp_q[digit_q];
  end

  // State, frame snapshot and registered outputs; wrap_q delays frame_done to align with digit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q    <= '0;
      digit_q    <= '0;
      loaded_q   <= 1'b0;
      wrap_q     <= 1'b0;
      val_q      <= '0;
      dp_q       <= '0;
      blank_q    <= 1'b1;
      segments   <= 7'h7F;
      dp_out     <= 1'b1;
      an_out     <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      digit_q    <= digit_d;
      loaded_q   <= 1'b1;
      wrap_q     <= wrap_d;
      val_q      <= reload ? display_val : val_q;
      dp_q       <= reload ? dp : dp_q;
      blank_q    <= reload ? blank : blank_q;
      segments   <= seg_d;
      dp_out     <= dp_d;
      an_out     <= an_d;
      frame_done <= wrap_q;
    end
  end
endmodule

// File: doc/seven_segment_mux.md
SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 Parameter CLK_FREQUENCY, default 100_000_000, SHALL give the clk frequency in Hz.
REQ-002 Parameter MIN_SEGMENT_DISPLAY_US, default 10_000, SHALL give the per-digit on-time in microseconds.
REQ-003 Local DIGIT_CLOCKS = CLK_FREQUENCY/1_000_000*MIN_SEGMENT_DISPLAY_US; elaboration SHALL fail (fatal) if DIGIT_CLOCKS < 2.
REQ-004 Port clk, input, 1: the single clock; all state on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port display_val, input, 32: eight hex nibbles; nibble i ([4i+3:4i]) shown on digit i.
REQ-007 Port dp, input, 8: dp[i]=1 lights the decimal point of digit i.
REQ-008 Port blank, input, 1: 1 = display dark for the whole frame.
REQ-009 Port segments, output, 7: active-low; [6]=A, [5]=B, [4]=C, [3]=D, [2]=E, [1]=F, [0]=G.
REQ-010 Port dp_out, output, 1: active-low decimal point.
REQ-011 Port an_out, output, 8: active-low anodes; at most one bit low in any cycle.
REQ-012 Port frame_done, output, 1: one-cycle pulse at each frame end.

Function
REQ-013 Segment encoding (ABCDEFG) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-014 State: timer 0..DIGIT_CLOCKS-1, digit index 0..7, loaded flag, shadow registers (value, dp, blank).
REQ-015 While loaded=0: the shadow registers SHALL load display_val/dp/blank, loaded SHALL be set to 1, and timer SHALL hold at 0.
REQ-016 While loaded=1: timer SHALL increment each cycle; at DIGIT_CLOCKS-1 it SHALL wrap to 0 and the digit index SHALL advance (7 wraps to 0).
REQ-017 On the wrap from digit 7 to digit 0, the shadow registers SHALL reload from the inputs; input changes at any other time SHALL NOT affect the frame in progress.
REQ-018 segments, dp_out, an_out and frame_done SHALL be registered and computed from the current digit index and shadow registers, one cycle after the state they reflect.
REQ-019 Shadow blank=0: an_out SHALL be ~(8'b1 << digit), segments SHALL be the encoding of the digit's nibble, and dp_out SHALL be ~dp[digit].
REQ-020 Shadow blank=1: an_out SHALL be 8'hFF, segments SHALL be 7'h7F, dp_out SHALL be 1; timer and digit sequencing SHALL continue unchanged.
REQ-021 In steady state, each anode SHALL stay low for exactly DIGIT_CLOCKS cycles; each an_out transition SHALL move directly from one digit to the next, with no all-high gap.
REQ-022 frame_done SHALL pulse high for 1 cycle in the same cycle an_out first shows digit 0 of a new frame, and SHALL not pulse for the first frame after reset.
REQ-023 Digit order SHALL be 0,1,...,7 (an_out[0] first).

Reset
REQ-024 While rst=1 (asynchronously): an_out=8'hFF, segments=7'h7F, dp_out=1, frame_done=0, timer=0, digit=0, loaded=0, shadow blank=1.
REQ-025 After rst deasserts, an_out SHALL be 8'hFF at the first edge and show digit 0 from the second edge onward.
REQ-026 Reset asserted mid-frame SHALL return all outputs to the reset values immediately; no partial frame SHALL resume.

Verification (CLK_FREQUENCY=1_000_000, MIN_SEGMENT_DISPLAY_US=10 -> DIGIT_CLOCKS=10)
REQ-027 Hold display_val=32'h0123_4567, dp=8'h00, blank=0, then release reset. Required:
- an_out=8'hFE with segments=0001111 for 10 cycles;
- then digits 1..7 in order (digit 7: an_out=8'h7F, segments=0000001);
- frame_done pulses when digit 0 returns.
REQ-028 Set display_val=32'hFEDC_BA98 and dp=8'h81. Required:
- digit 0 segments=0000000 with dp_out=0;
- digit 7 segments=0111000 with dp_out=0;
- all other digits dp_out=1.
REQ-029 Change display_val while digit 3 is shown. Required: digits 4..7 keep the old nibbles; the new value appears starting at the next digit 0.
REQ-030 Set blank=1 mid-frame. Required: the current frame completes normally, then an_out=8'hFF for the next frame; frame_done keeps pulsing every 80 cycles.
REQ-031 Assert rst while digit 5 is shown. Required: outputs go to the reset values within the same cycle; after release the sequence restarts at digit 0 per REQ-025.
REQ-032 Run a bench monitor across all scenarios. Required: at most one an_out bit is ever low, and every anode dwell is exactly 10 cycles.
